// File: rtl/servant_pll_reset_seq.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses PLL RST, waits for lock with retries, releases o_rst.
// Optional status outputs (o_retries, o_lock_lost) are enabled by defining SERVANT_PLL_SEQ_STATUS_EN.
module servant_pll_reset_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_locked,
  output logic o_pll_rst,
  output logic o_rst,
  output logic o_locked,
  output logic o_fail
`ifdef SERVANT_PLL_SEQ_STATUS_EN
  ,
  output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] o_retries,
  output logic o_lock_lost
`endif
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  state_e        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [RW-1:0] retries, retries_next;
  logic          locked_meta, locked_s;
  logic          pll_rst_d, rst_d, locked_d, fail_d;

  // State, counters, lock synchronizer and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      retries     <= '0;
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
      o_pll_rst   <= 1'b1;
      o_rst       <= 1'b1;
      o_locked    <= 1'b0;
      o_fail      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      retries     <= retries_next;
      locked_meta <= i_locked;
      locked_s    <= locked_meta;
      o_pll_rst   <= pll_rst_d;
      o_rst       <= rst_d;
      o_locked    <= locked_d;
      o_fail      <= fail_d;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CW'(1);
    retries_next = retries;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_next = '0;
          if (retries == RETRY_LAST) begin
            state_next = FAIL;
          end else begin
            state_next   = PLL_RST;
            retries_next = retries + RW'(1);
          end
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        cnt_next = cnt;
        if (!locked_s) begin
          state_next   = PLL_RST;
          cnt_next     = '0;
          retries_next = '0;
        end
      end
      FAIL: begin
        cnt_next = cnt;
      end
      default: begin
        state_next   = PLL_RST;
        cnt_next     = '0;
        retries_next = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_comb begin
    pll_rst_d = 1'b1;
    rst_d     = 1'b1;
    locked_d  = 1'b0;
    fail_d    = 1'b0;
    case (state_next)
      WAIT_LOCK, STABLE: pll_rst_d = 1'b0;
      RUN: begin
        pll_rst_d = 1'b0;
        rst_d     = 1'b0;
        locked_d  = 1'b1;
      end
      FAIL:    fail_d = 1'b1;
      default: pll_rst_d = 1'b1;
    endcase
  end

`ifdef SERVANT_PLL_SEQ_STATUS_EN
  logic lock_lost;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_lost <= 1'b0;
    end else if (state == RUN && state_next == PLL_RST) begin
      lock_lost <= 1'b1;
    end
  end

  assign o_retries   = retries;
  assign o_lock_lost = lock_lost;
`endif

endmodule

// File: tb/tb_servant_pll_reset_seq.sv
// Directed testbench for servant_pll_reset_seq; status outputs are checked when SERVANT_PLL_SEQ_STATUS_EN is defined.
module tb_servant_pll_reset_seq;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_locked;
  logic o_pll_rst, o_rst, o_locked, o_fail;
`ifdef SERVANT_PLL_SEQ_STATUS_EN
  logic [1:0] o_retries;
  logic       o_lock_lost;
`endif

  int checks = 0;
  int errors = 0;

  servant_pll_reset_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_locked (i_locked),
    .o_pll_rst(o_pll_rst),
    .o_rst    (o_rst),
    .o_locked (o_locked),
    .o_fail   (o_fail)
`ifdef SERVANT_PLL_SEQ_STATUS_EN
    ,
    .o_retries  (o_retries),
    .o_lock_lost(o_lock_lost)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Returns 1 unit after the edge that sampled i_rst high (sample index 0).
  task automatic pulse_reset();
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst    = 1'b1;
    i_locked = 1'b0;
    tick(3);
    checks++;
    if (o_pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset pll_rst got %b exp 1", o_pll_rst); end
    checks++;
    if (o_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset rst got %b exp 1", o_rst); end
    checks++;
    if (o_locked !== 1'b0) begin errors++; $display("[TB] FAIL reset locked got %b exp 0", o_locked); end
    checks++;
    if (o_fail !== 1'b0) begin errors++; $display("[TB] FAIL reset fail got %b exp 0", o_fail); end
`ifdef SERVANT_PLL_SEQ_STATUS_EN
    checks++;
    if (o_retries !== 2'd0) begin errors++; $display("[TB] FAIL reset retries got %0d exp 0", o_retries); end
    checks++;
    if (o_lock_lost !== 1'b0) begin errors++; $display("[TB] FAIL reset lock_lost got %b exp 0", o_lock_lost); end
`endif
  endtask

  // Lock driven after edge 10: sync to edge 12, STABLE at edge 13, RUN 8 edges later at 21.
  task automatic test_lock_sequence();
    logic exp_pll, exp_rst;
    i_locked = 1'b0;
    pulse_reset();
    for (int n = 0; n < 24; n++) begin
      exp_pll = (n < 4);
      exp_rst = (n < 21);
      checks++;
      if (o_pll_rst !== exp_pll) begin errors++; $display("[TB] FAIL lock_seq pll_rst n=%0d got %b exp %b", n, o_pll_rst, exp_pll); end
      checks++;
      if (o_rst !== exp_rst) begin errors++; $display("[TB] FAIL lock_seq rst n=%0d got %b exp %b", n, o_rst, exp_rst); end
      checks++;
      if (o_locked !== !exp_rst) begin errors++; $display("[TB] FAIL lock_seq locked n=%0d got %b exp %b", n, o_locked, !exp_rst); end
      checks++;
      if (o_fail !== 1'b0) begin errors++; $display("[TB] FAIL lock_seq fail n=%0d got %b exp 0", n, o_fail); end
      if (n == 10) i_locked = 1'b1;
      tick(1);
    end
  endtask

  // Lock at 6 (STABLE at 9), one-cycle drop at 11 (back to WAIT at 14), relock at 12 (STABLE at 15, RUN at 23).
  task automatic test_glitch();
    logic exp_pll, exp_rst;
    i_locked = 1'b0;
    pulse_reset();
    for (int n = 0; n < 27; n++) begin
      exp_pll = (n < 4);
      exp_rst = (n < 23);
      checks++;
      if (o_pll_rst !== exp_pll) begin errors++; $display("[TB] FAIL glitch pll_rst n=%0d got %b exp %b", n, o_pll_rst, exp_pll); end
      checks++;
      if (o_rst !== exp_rst) begin errors++; $display("[TB] FAIL glitch rst n=%0d got %b exp %b", n, o_rst, exp_rst); end
      if (n == 6)  i_locked = 1'b1;
      if (n == 11) i_locked = 1'b0;
      if (n == 12) i_locked = 1'b1;
      tick(1);
    end
  endtask

  // Each attempt is 4 reset cycles + 32 wait cycles; third timeout at edge 108 enters FAIL.
  task automatic test_timeout_fail();
    logic exp_pll, exp_fail;
    int   exp_ret;
    i_locked = 1'b0;
    pulse_reset();
    for (int n = 0; n < 115; n++) begin
      exp_fail = (n >= 108);
      exp_pll  = exp_fail || ((n % 36) < 4);
      exp_ret  = (n >= 108) ? 2 : (n / 36);
      checks++;
      if (o_pll_rst !== exp_pll) begin errors++; $display("[TB] FAIL timeout pll_rst n=%0d got %b exp %b", n, o_pll_rst, exp_pll); end
      checks++;
      if (o_fail !== exp_fail) begin errors++; $display("[TB] FAIL timeout fail n=%0d got %b exp %b", n, o_fail, exp_fail); end
      checks++;
      if (o_rst !== 1'b1) begin errors++; $display("[TB] FAIL timeout rst n=%0d got %b exp 1", n, o_rst); end
`ifdef SERVANT_PLL_SEQ_STATUS_EN
      checks++;
      if (o_retries !== 2'(exp_ret)) begin errors++; $display("[TB] FAIL timeout retries n=%0d got %0d exp %0d", n, o_retries, exp_ret); end
`else
      if (exp_ret > 2) begin errors++; $display("[TB] FAIL timeout model retries n=%0d got %0d exp <=2", n, exp_ret); end
`endif
      tick(1);
    end
    pulse_reset();
    checks++;
    if (o_fail !== 1'b0) begin errors++; $display("[TB] FAIL fail_clear fail got %b exp 0", o_fail); end
    checks++;
    if (o_pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL fail_clear pll_rst got %b exp 1", o_pll_rst); end
  endtask

  // RUN reached on the second attempt, then lock loss; two further timeouts must not cause FAIL.
  task automatic test_lock_loss();
    i_locked = 1'b0;
    pulse_reset();
    tick(40);
    i_locked = 1'b1;
    tick(10);
    checks++;
    if (o_rst !== 1'b1) begin errors++; $display("[TB] FAIL loss pre_run rst n=50 got %b exp 1", o_rst); end
    tick(1);
    checks++;
    if (o_rst !== 1'b0) begin errors++; $display("[TB] FAIL loss run rst n=51 got %b exp 0", o_rst); end
    checks++;
    if (o_locked !== 1'b1) begin errors++; $display("[TB] FAIL loss run locked n=51 got %b exp 1", o_locked); end
`ifdef SERVANT_PLL_SEQ_STATUS_EN
    checks++;
    if (o_retries !== 2'd1) begin errors++; $display("[TB] FAIL loss run retries got %0d exp 1", o_retries); end
`endif
    i_locked = 1'b0;
    tick(2);
    checks++;
    if (o_rst !== 1'b0) begin errors++; $display("[TB] FAIL loss early rst n=53 got %b exp 0", o_rst); end
    tick(1);
    checks++;
    if (o_rst !== 1'b1) begin errors++; $display("[TB] FAIL loss drop rst n=54 got %b exp 1", o_rst); end
    checks++;
    if (o_locked !== 1'b0) begin errors++; $display("[TB] FAIL loss drop locked n=54 got %b exp 0", o_locked); end
    checks++;
    if (o_pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL loss drop pll_rst n=54 got %b exp 1", o_pll_rst); end
`ifdef SERVANT_PLL_SEQ_STATUS_EN
    checks++;
    if (o_retries !== 2'd0) begin errors++; $display("[TB] FAIL loss drop retries got %0d exp 0", o_retries); end
    checks++;
    if (o_lock_lost !== 1'b1) begin errors++; $display("[TB] FAIL loss lock_lost got %b exp 1", o_lock_lost); end
`endif
    tick(3);
    checks++;
    if (o_pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL loss pulse_end pll_rst n=57 got %b exp 1", o_pll_rst); end
    tick(1);
    checks++;
    if (o_pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL loss pulse_done pll_rst n=58 got %b exp 0", o_pll_rst); end
    tick(73);
    checks++;
    if (o_fail !== 1'b0) begin errors++; $display("[TB] FAIL loss retry_reset fail n=131 got %b exp 0", o_fail); end
    checks++;
    if (o_pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL loss third_wait pll_rst n=131 got %b exp 0", o_pll_rst); end
    i_locked = 1'b1;
    tick(10);
    checks++;
    if (o_rst !== 1'b1) begin errors++; $display("[TB] FAIL relock pre_run rst n=141 got %b exp 1", o_rst); end
    tick(1);
    checks++;
    if (o_rst !== 1'b0) begin errors++; $display("[TB] FAIL relock rst n=142 got %b exp 0", o_rst); end
    checks++;
    if (o_locked !== 1'b1) begin errors++; $display("[TB] FAIL relock locked n=142 got %b exp 1", o_locked); end
`ifdef SERVANT_PLL_SEQ_STATUS_EN
    checks++;
    if (o_lock_lost !== 1'b1) begin errors++; $display("[TB] FAIL relock lock_lost held got %b exp 1", o_lock_lost); end
`endif
  endtask

  // Reset mid-STABLE: 4-cycle pulse, WAIT at m=4, STABLE at m=5, RUN at m=13.
  task automatic test_reset_mid_stable();
    logic exp_pll, exp_rst;
    i_locked = 1'b0;
    pulse_reset();
`ifdef SERVANT_PLL_SEQ_STATUS_EN
    checks++;
    if (o_lock_lost !== 1'b0) begin errors++; $display("[TB] FAIL mid_stable lock_lost cleared got %b exp 0", o_lock_lost); end
`endif
    tick(6);
    i_locked = 1'b1;
    tick(5);
    checks++;
    if (o_rst !== 1'b1) begin errors++; $display("[TB] FAIL mid_stable pre rst got %b exp 1", o_rst); end
    checks++;
    if (o_pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL mid_stable pre pll_rst got %b exp 0", o_pll_rst); end
    pulse_reset();
    for (int m = 0; m < 15; m++) begin
      exp_pll = (m < 4);
      exp_rst = (m < 13);
      checks++;
      if (o_pll_rst !== exp_pll) begin errors++; $display("[TB] FAIL mid_stable pll_rst m=%0d got %b exp %b", m, o_pll_rst, exp_pll); end
      checks++;
      if (o_rst !== exp_rst) begin errors++; $display("[TB] FAIL mid_stable rst m=%0d got %b exp %b", m, o_rst, exp_rst); end
      tick(1);
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_glitch();
    test_timeout_fail();
    test_lock_loss();
    test_reset_mid_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got timeout exp completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
